// File: rtl/work_frame_loader.sv
// Host-link job loader: sync 0xA5, 56 payload bytes, XOR checksum; validates, commits the job, pulses job_start.
// Job outputs and job_start appear one cycle after the checksum byte; in_ready drops only in reset and the COMMIT cycle.
module work_frame_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         hash_clk,
    input  logic         reset_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] midstate_vw,
    output logic [95:0]  work_data,
    output logic [31:0]  nonce_min,
    output logic [31:0]  nonce_max,
    output logic         job_start,
    output logic [7:0]   frame_err_cnt,
    output logic [1:0]   last_err
);
    localparam int unsigned   CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CKSUM, S_COMMIT} state_t;

    state_t          state_q, state_d;
    logic            live_q;
    logic [5:0]      idx_q, idx_d;
    logic [7:0]      xor_q, xor_d;
    // The job fields fill the low 416 bits; the first four payload bytes shift out
    // the top and only contribute to the checksum.
    logic [415:0]    stage_q, stage_d;
    logic [CW-1:0]   to_cnt_q, to_cnt_d;
    logic [255:0]    mid_q, mid_d;
    logic [95:0]     work_q, work_d;
    logic [31:0]     nmin_q, nmin_d;
    logic [31:0]     nmax_q, nmax_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [1:0]      last_err_q, last_err_d;
    logic            xfer;
    logic            err_vld;
    logic [1:0]      err_code;

    assign in_ready = live_q && (state_q != S_COMMIT);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        xor_d      = xor_q;
        stage_d    = stage_q;
        to_cnt_d   = to_cnt_q;
        mid_d      = mid_q;
        work_d     = work_q;
        nmin_d     = nmin_q;
        nmax_d     = nmax_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;
        err_vld    = 1'b0;
        err_code   = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (xfer && (in_data == 8'hA5)) begin
                    state_d  = S_PAYLOAD;
                    idx_d    = 6'd0;
                    xor_d    = 8'h00;
                    to_cnt_d = '0;
                end
            end
            S_PAYLOAD, S_CKSUM: begin
                if (xfer) begin
                    to_cnt_d = '0;
                    if (state_q == S_PAYLOAD) begin
                        stage_d = {stage_q[407:0], in_data};
                        xor_d   = xor_q ^ in_data;
                        idx_d   = idx_q + 6'd1;
                        if (idx_q == 6'd55) state_d = S_CKSUM;
                    end else begin
                        state_d = S_IDLE;
                        if (in_data != xor_q) begin
                            err_vld  = 1'b1;
                            err_code = 2'd1;
                        end else if (stage_q[63:32] > stage_q[31:0]) begin
                            err_vld  = 1'b1;
                            err_code = 2'd2;
                        end else begin
                            mid_d   = stage_q[415:160];
                            work_d  = stage_q[159:64];
                            nmin_d  = stage_q[63:32];
                            nmax_d  = stage_q[31:0];
                            state_d = S_COMMIT;
                        end
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (to_cnt_q == TO_LAST) begin
                        state_d  = S_IDLE;
                        to_cnt_d = '0;
                        err_vld  = 1'b1;
                        err_code = 2'd3;
                    end else begin
                        to_cnt_d = to_cnt_q + CW'(1);
                    end
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (err_vld) begin
            last_err_d = err_code;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            live_q     <= 1'b0;
            idx_q      <= '0;
            xor_q      <= '0;
            stage_q    <= '0;
            to_cnt_q   <= '0;
            mid_q      <= '0;
            work_q     <= '0;
            nmin_q     <= '0;
            nmax_q     <= '0;
            err_cnt_q  <= '0;
            last_err_q <= '0;
        end else begin
            state_q    <= state_d;
            live_q     <= 1'b1;
            idx_q      <= idx_d;
            xor_q      <= xor_d;
            stage_q    <= stage_d;
            to_cnt_q   <= to_cnt_d;
            mid_q      <= mid_d;
            work_q     <= work_d;
            nmin_q     <= nmin_d;
            nmax_q     <= nmax_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
        end
    end

    assign midstate_vw   = mid_q;
    assign work_data     = work_q;
    assign nonce_min     = nmin_q;
    assign nonce_max     = nmax_q;
    assign job_start     = (state_q == S_COMMIT);
    assign frame_err_cnt = err_cnt_q;
    assign last_err      = last_err_q;
endmodule
